mem_word_ctrl: RTL



---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_word_ctrl_if.sv | 41 ++++
 rtl/mem_word_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the byte/word memory access sequencer.
//   state_t           controller states (IDLE, LO, HI, RESP)
//   SIZE_BYTE/WORD    encodings of the req_size request field
//   RWN_READ/WRITE    encodings of the memory readwriteN strobe
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    localparam logic RWN_READ  = 1'b1;
    localparam logic RWN_WRITE = 1'b0;

endpackage

// File: rtl/mem_word_ctrl_if.sv
// mem_word_ctrl_if: request/response handshake plus the 8-bit memory bus.
//   req_valid/req_ready     request handshake (requester -> controller)
//   req_write, req_size     1=store/0=load, 1=word/0=byte
//   req_addr, req_wdata     byte address and store data
//   rsp_valid, rsp_rdata    one-cycle completion pulse and load data
//   mem_rwn, mem_addr,
//   mem_wdata, mem_rdata    byte-wide memory port (readwriteN, 1=read)
// Modports: master (requester), slave (controller), mem_side (memory).
interface mem_word_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int BYTE_W = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic                  req_size;
    logic [ADDR_W-1:0]     req_addr;
    logic [2*BYTE_W-1:0]   req_wdata;
    logic                  rsp_valid;
    logic [2*BYTE_W-1:0]   rsp_rdata;
    logic                  mem_rwn;
    logic [ADDR_W-1:0]     mem_addr;
    logic [BYTE_W-1:0]     mem_wdata;
    logic [BYTE_W-1:0]     mem_rdata;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, mem_rwn, mem_addr, mem_wdata
    );

    modport mem_side (
        input  mem_rwn, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_word_ctrl.sv
// mem_word_ctrl: sequences byte or 16-bit word loads/stores onto a byte-wide,
// negedge-clocked memory. Words are split into two little-endian byte
// accesses (low byte at addr, high byte at addr+1, wrapping) and load data
// is reassembled into rsp_rdata.
//   clk    single clock, all state updates on posedge
//   rst_n  asynchronous active-low reset
//   bus    mem_word_ctrl_if.slave: request handshake, response pulse and
//          memory-side strobes (all memory-side outputs registered)
module mem_word_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int BYTE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_word_ctrl_if.slave        bus
);

    state_t                state, state_n;

    // Request fields latched at acceptance; the low store byte goes straight
    // to mem_wdata, so only the high byte needs keeping.
    logic                  wr_q,       wr_n;
    logic                  size_q,     size_n;
    logic [ADDR_W-1:0]     addr_q,     addr_n;
    logic [BYTE_W-1:0]     wdata_hi_q, wdata_hi_n;
    logic [BYTE_W-1:0]     rdata_lo_q, rdata_lo_n;

    logic                  mem_rwn_q,   mem_rwn_n;
    logic [ADDR_W-1:0]     mem_addr_q,  mem_addr_n;
    logic [BYTE_W-1:0]     mem_wdata_q, mem_wdata_n;
    logic [2*BYTE_W-1:0]   rsp_rdata_q, rsp_rdata_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_q        <= 1'b0;
            size_q      <= 1'b0;
            addr_q      <= '0;
            wdata_hi_q  <= '0;
            rdata_lo_q  <= '0;
            mem_rwn_q   <= RWN_READ;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state       <= state_n;
            wr_q        <= wr_n;
            size_q      <= size_n;
            addr_q      <= addr_n;
            wdata_hi_q  <= wdata_hi_n;
            rdata_lo_q  <= rdata_lo_n;
            mem_rwn_q   <= mem_rwn_n;
            mem_addr_q  <= mem_addr_n;
            mem_wdata_q <= mem_wdata_n;
            rsp_rdata_q <= rsp_rdata_n;
        end
    end

    // Next-state logic also computes the next value of every registered
    // memory-side output, so the memory sees clean strobes at the negedge.
    always_comb begin
        state_n     = state;
        wr_n        = wr_q;
        size_n      = size_q;
        addr_n      = addr_q;
        wdata_hi_n  = wdata_hi_q;
        rdata_lo_n  = rdata_lo_q;
        mem_rwn_n   = mem_rwn_q;
        mem_addr_n  = mem_addr_q;
        mem_wdata_n = mem_wdata_q;
        rsp_rdata_n = rsp_rdata_q;

        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    wr_n        = bus.req_write;
                    size_n      = bus.req_size;
                    addr_n      = bus.req_addr;
                    wdata_hi_n  = bus.req_wdata[2*BYTE_W-1:BYTE_W];
                    mem_addr_n  = bus.req_addr;
                    mem_wdata_n = bus.req_wdata[BYTE_W-1:0];
                    mem_rwn_n   = bus.req_write ? RWN_WRITE : RWN_READ;
                    state_n     = LO;
                end
            end
            LO: begin
                if (size_q == SIZE_WORD) begin
                    if (!wr_q) begin
                        rdata_lo_n = bus.mem_rdata;
                    end
                    mem_addr_n  = addr_q + ADDR_W'(1);
                    mem_wdata_n = wdata_hi_q;
                    state_n     = HI;
                end else begin
                    if (!wr_q) begin
                        rsp_rdata_n = {{BYTE_W{1'b0}}, bus.mem_rdata};
                    end
                    mem_rwn_n = RWN_READ;
                    state_n   = RESP;
                end
            end
            HI: begin
                if (!wr_q) begin
                    rsp_rdata_n = {bus.mem_rdata, rdata_lo_q};
                end
                mem_rwn_n = RWN_READ;
                state_n   = RESP;
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                mem_rwn_n = RWN_READ;
                state_n   = IDLE;
            end
        endcase
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_rwn   = mem_rwn_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule
